// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with a pass-through destination tag and a kill input.
module muldiv_unit #(
   parameter int DWIDTH = 32,
   parameter int TAGW   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DWIDTH-1:0] rs1_i,
   input  logic [DWIDTH-1:0] rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [TAGW-1:0]   tag_i,
   input  logic              kill_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] res_o,
   output logic [TAGW-1:0]   tag_o,
   output logic              busy_o
);

   localparam int CW = $clog2(DWIDTH + 1);
   localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Handshake: a request transfers on a rising edge where valid_i && ready_o && !kill_i;
   // a result transfers on a rising edge where valid_o && ready_i. valid_o and res_o/tag_o
   // hold until that transfer (or a kill/reset), and ready_o is high only in IDLE.
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*DWIDTH-1:0] acc_q, acc_d;
   logic [DWIDTH-1:0]   opb_q, opb_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;
   logic [DWIDTH-1:0]   res_q, res_d;
   logic [TAGW-1:0]     tag_q, tag_d;
   logic                valid_q, valid_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;

   logic                signed_a, signed_b, a_neg, b_neg;
   logic [DWIDTH-1:0]   a_mag, b_mag;
   logic                div_zero, div_ovf;
   logic [DWIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*DWIDTH-1:0] acc_step, prod;
   logic [DWIDTH-1:0]   step_lo, step_hi;

   always_comb begin
      signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b110);
      signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
      a_neg    = signed_a && rs1_i[DWIDTH-1];
      b_neg    = signed_b && rs2_i[DWIDTH-1];
      a_mag    = a_neg ? -rs1_i : rs1_i;
      b_mag    = b_neg ? -rs2_i : rs2_i;
      div_zero = funct3_i[2] && (rs2_i == '0);
      div_ovf  = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);

      // Multiply: acc = {partial, multiplier}; add multiplicand on the LSB, shift right.
      mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} +
                  ({1'b0, opb_q} & {(DWIDTH+1){acc_q[0]}});
      // Divide: acc = {remainder, dividend/quotient}; trial-subtract, keep if non-negative.
      div_shift = acc_q[2*DWIDTH-1:DWIDTH-1];
      div_diff  = div_shift - {1'b0, opb_q};
      if (f3_q[2]) begin
         if (div_diff[DWIDTH])
            acc_step = {div_shift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
         else
            acc_step = {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc_q[DWIDTH-1:1]};
      end
      prod    = neg_q ? -acc_step : acc_step;
      step_lo = acc_step[DWIDTH-1:0];
      step_hi = acc_step[2*DWIDTH-1:DWIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      res_d   = res_q;
      tag_d   = tag_q;
      if (kill_i && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i && !kill_i) begin
                  f3_d  = funct3_i;
                  tag_d = tag_i;
                  neg_d = (funct3_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
                  if (div_zero) begin
                     res_d   = funct3_i[1] ? rs1_i : '1;
                     state_d = DONE;
                  end else if (div_ovf) begin
                     res_d   = funct3_i[1] ? '0 : rs1_i;
                     state_d = DONE;
                  end else begin
                     acc_d   = funct3_i[2] ? {{DWIDTH{1'b0}}, a_mag} : {{DWIDTH{1'b0}}, b_mag};
                     opb_d   = funct3_i[2] ? b_mag : a_mag;
                     cnt_d   = CW'(DWIDTH);
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               acc_d = acc_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  if (!f3_q[2])
                     res_d = (f3_q == 3'b000) ? prod[DWIDTH-1:0] : prod[2*DWIDTH-1:DWIDTH];
                  else if (f3_q[1])
                     res_d = neg_q ? -step_hi : step_hi;
                  else
                     res_d = neg_q ? -step_lo : step_lo;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (ready_i)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      valid_d = (state_d == DONE);
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign res_o   = res_q;
   assign tag_o   = tag_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: the driver pushes expected {tag, result} into a queue
// and an independent monitor pops and compares on every result transfer.
module tb_muldiv_unit;

   localparam int DW = 32;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [DW-1:0] rs1_i = '0;
   logic [DW-1:0] rs2_i = '0;
   logic [2:0]    funct3_i = '0;
   logic [TW-1:0] tag_i = '0;
   logic          kill_i = 1'b0;
   logic          valid_o;
   logic          ready_i = 1'b1;
   logic [DW-1:0] res_o;
   logic [TW-1:0] tag_o;
   logic          busy_o;

   logic [TW+DW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]    f3;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] r;
      int            lat;
   } vec_t;

   vec_t vecs[20];

   muldiv_unit #(.DWIDTH(DW), .TAGW(TW)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .tag_i(tag_i),
      .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
      .res_o(res_o), .tag_o(tag_o), .busy_o(busy_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got res 0x%0h tag %0d, expected no result", res_o, tag_o);
         end else begin
            logic [TW+DW-1:0] e;
            e = exp_q.pop_front();
            check("res", res_o, e[DW-1:0]);
            check("tag", tag_o, e[TW+DW-1:DW]);
         end
      end
   end

   // driver tasks
   task automatic issue(input bit sync, input logic [2:0] f3, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] tg,
                        input logic [DW-1:0] er, input bit expect_res, output int waits);
      if (sync) begin
         @(posedge clk);
         #1;
      end
      valid_i  = 1'b1;
      funct3_i = f3;
      rs1_i    = a;
      rs2_i    = b;
      tag_i    = tg;
      waits    = 0;
      while (!ready_o && waits < 100) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (waits >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got ready_o 0 for %0d cycles, expected 1", waits);
      end
      if (expect_res) exp_q.push_back({tg, er});
      @(posedge clk);
      #1;
      valid_i  = 1'b0;
      rs1_i    = $urandom;
      rs2_i    = $urandom;
      funct3_i = 3'($urandom_range(0, 7));
      tag_i    = TW'($urandom_range(0, 31));
   endtask

   task automatic wait_done(input string nm, input int exp_lat);
      int n;
      int rdy;
      n   = 0;
      rdy = 0;
      do begin
         @(negedge clk);
         n++;
         if (ready_o) rdy++;
      end while (!valid_o && n < 200);
      check({nm, "_latency"}, 64'(n), 64'(exp_lat));
      check({nm, "_ready_low"}, 64'(rdy), 64'd0);
   endtask

   initial begin
      int w;
      int bad;
      int vcount;

      vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
      vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
      vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
      vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
      vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
      vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
      vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{3'b001, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF, 33};
      vecs[13] = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 33};
      vecs[14] = '{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33};
      vecs[15] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33};
      vecs[16] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 33};
      vecs[17] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
      vecs[18] = '{3'b111, 32'd7,        32'd0,        32'd7,        1};
      vecs[19] = '{3'b011, 32'h80000000, 32'd2,        32'd1,        33};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", valid_o, 0);
      check("reset_res", res_o, 0);
      check("reset_tag", tag_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_ready", ready_o, 1);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         logic [TW-1:0] tg;
         tg = (i == 0) ? TW'(5) : TW'(i + 1);
         issue(1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, tg, vecs[i].r, 1'b1, w);
         wait_done($sformatf("vec%0d", i), vecs[i].lat);
      end

      // backpressure: result held while ready_i is low; stray request must be ignored
      @(posedge clk);
      #1 ready_i = 1'b0;
      issue(1'b0, 3'b011, 32'h00010000, 32'h00010000, 5'd9, 32'd1, 1'b1, w);
      wait_done("bp", 33);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            valid_i  = 1'b1;
            funct3_i = 3'b000;
            rs1_i    = 32'd2;
            rs2_i    = 32'd2;
            tag_i    = 5'd3;
         end
         @(negedge clk);
         if (!valid_o || ready_o || busy_o !== 1'b1 || res_o !== 32'd1 || tag_o !== 5'd9) bad++;
      end
      check("bp_hold_cycles_bad", 64'(bad), 64'd0);
      @(posedge clk);
      #1 ready_i = 1'b1;
      issue(1'b0, 3'b000, 32'd2, 32'd3, 5'd12, 32'd6, 1'b1, w);
      check("bp_next_accept_wait", 64'(w), 64'd1);
      wait_done("bp_next", 33);

      // kill in IDLE suppresses acceptance
      @(posedge clk);
      #1;
      valid_i  = 1'b1;
      kill_i   = 1'b1;
      funct3_i = 3'b000;
      rs1_i    = 32'd4;
      rs2_i    = 32'd4;
      tag_i    = 5'd1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      kill_i  = 1'b0;
      @(negedge clk);
      check("idle_kill_busy", busy_o, 0);
      check("idle_kill_ready", ready_o, 1);

      // kill in CALC cycle 10
      issue(1'b1, 3'b000, 32'h1234, 32'd5, 5'd7, 32'd0, 1'b0, w);
      repeat (9) @(posedge clk);
      #1 kill_i = 1'b1;
      @(posedge clk);
      #1 kill_i = 1'b0;
      @(negedge clk);
      check("kill_busy", busy_o, 0);
      check("kill_ready", ready_o, 1);
      check("kill_valid", valid_o, 0);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_o) vcount++;
      end
      check("kill_no_valid_cycles", 64'(vcount), 64'd0);
      issue(1'b1, 3'b101, 32'd9, 32'd3, 5'd20, 32'd3, 1'b1, w);
      wait_done("after_kill", 33);

      // reset mid-CALC
      issue(1'b1, 3'b100, 32'd1000, 32'd3, 5'd13, 32'd0, 1'b0, w);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_valid", valid_o, 0);
      check("midrst_res", res_o, 0);
      check("midrst_tag", tag_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_ready", ready_o, 1);
      issue(1'b1, 3'b111, 32'd100, 32'd7, 5'd21, 32'd2, 1'b1, w);
      wait_done("after_reset", 33);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Takes the same rs1/rs2/funct3 operands when the instruction is OP with funct7 = 0000001.
- Uses a valid/ready handshake on both input and output so the pipeline can stall on it.
- Carries a destination tag through so the result can be written back, and accepts a kill for squashed instructions.

Parameters:
- DWIDTH, 32: operand and result width; must be even and at least 8.
- TAGW, 5: width of the pass-through destination tag (rd index).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept a request this cycle
- rs1_i  in  DWIDTH  operand A (dividend / multiplicand)
- rs2_i  in  DWIDTH  operand B (divisor / multiplier)
- funct3_i  in  3  M-extension op select
- tag_i  in  TAGW  destination tag
- kill_i  in  1  abort the in-flight operation
- valid_o  out  1  result available
- ready_i  in  1  consumer accepts result
- res_o  out  DWIDTH  result
- tag_o  out  TAGW  tag of result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (synchronous): state = IDLE, counter = 0, valid_o = 0, res_o = 0, tag_o = 0, busy_o = 0, ready_o = 1 in the following cycle.
- funct3 encoding:
  - 000 MUL (low half)
  - 001 MULH (signed x signed, high half)
  - 010 MULHSU (signed rs1 x unsigned rs2, high half)
  - 011 MULHU (high half)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- States:
  - IDLE: ready_o = 1. On valid_i && ready_o, latch operands, funct3 and tag. Compute operand magnitudes and the result sign for signed ops. Go to CALC with counter = DWIDTH, or to DONE for special cases.
  - CALC: one radix-2 iteration per cycle.
    - Multiply: shift-add into a 2*DWIDTH accumulator.
    - Divide: restoring shift-subtract on DWIDTH-bit remainder/quotient registers.
    - Counter decrements each cycle. At counter == 1, apply sign correction (two's-complement negate when required), select the high/low half or quotient/remainder into res_o, and go to DONE.
  - DONE: valid_o = 1, res_o and tag_o held stable. On ready_i, go to IDLE; valid_o drops the next cycle. No new request is accepted in DONE.
- Latency, with a request accepted at the clock edge ending cycle T:
  - Normal ops: valid_o first high in cycle T+DWIDTH+1.
  - Special cases: valid_o first high in cycle T+1.
  - Throughput is one op per DWIDTH+2 cycles when ready_i is held high.
- Special cases, resolved in IDLE with no iteration:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 1 followed by DWIDTH-1 zeros, and rs2 = all ones): DIV gives rs1, REM gives 0.
- Sign rules:
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - MULHSU treats only rs1 as signed.
  - All arithmetic is modulo 2^DWIDTH; the product is exact to 2*DWIDTH bits before the half is selected.
- kill_i:
  - In CALC or DONE: go to IDLE the next cycle, valid_o = 0, result discarded.
  - In IDLE: suppresses acceptance that cycle (kill wins over valid_i).
- reset mid-operation: same as kill, and res_o/tag_o are also cleared.
- Inputs are ignored outside an IDLE handshake. Changing rs1_i/rs2_i during CALC has no effect.

Test Plan:
- MUL 7 x 0xFFFFFFFD, tag 5 -> valid_o in cycle T+33 with res_o = 0xFFFFFFEB and tag_o = 5; ready_o = 0 in cycles T+1..T+33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF in T+1. REM 5 % 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in T+1. REM of the same operands -> 0.
- Backpressure: ready_i held 0 for 10 cycles after valid_o -> res_o/tag_o stable and no new request accepted; ready_i = 1 -> IDLE next cycle, and the next op is accepted that cycle.
- kill_i at CALC cycle 10 -> IDLE next cycle, valid_o never asserts; a following DIVU 9 / 3 returns 3. Reset asserted mid-CALC -> all outputs 0 the next cycle.
